// File: rtl/stream_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : stream_packer_if                                                  |
// | Brief  : Bundles the narrow input stream and the wide packed output        |
// |          stream of stream_packer.                                          |
// |          Signals:                                                          |
// |            idata/ilast/ivalid  -> packer   narrow beat, packet end, valid   |
// |            iready              <- packer   beat accepted                    |
// |            odata/okeep/olast/ovalid <- packer  packed word, lane mask,      |
// |                                                packet end, valid           |
// |            oready              -> packer   word accepted                    |
// |          Modports: slave = the packer itself, master = its environment.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface stream_packer_if #(
  parameter int IW    = 8,
  parameter int RATIO = 4
);
  logic [IW-1:0]       idata;
  logic                ilast;
  logic                ivalid;
  logic                iready;
  logic [IW*RATIO-1:0] odata;
  logic [RATIO-1:0]    okeep;
  logic                olast;
  logic                ovalid;
  logic                oready;

  modport slave (
    input  idata, ilast, ivalid, oready,
    output iready, odata, okeep, olast, ovalid
  );

  modport master (
    output idata, ilast, ivalid, oready,
    input  iready, odata, okeep, olast, ovalid
  );
endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : stream_packer                                                     |
// | Brief  : Packs IW-bit valid/ready beats into IW*RATIO-bit words, MSB lane  |
// |          first. ilast closes a partial word early; okeep marks the lanes   |
// |          that carry data (okeep[RATIO-1] is lane 0).                       |
// |          Ports:                                                            |
// |            clk  clock                                                      |
// |            rst  synchronous, active-high reset                             |
// |            bus  stream_packer_if.slave (input beats and packed words)      |
// |          Optional feature macro: STREAM_PACKER_TIMEOUT_EN                  |
// |            defined   -> a partial word idle for TIMEOUT cycles is flushed  |
// |                         with olast=0                                       |
// |            undefined -> partial words close only on ilast or a full word   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module stream_packer #(
  parameter int IW      = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  stream_packer_if.slave  bus
);

  localparam int OW = IW * RATIO;
  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $error("stream_packer: RATIO must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("stream_packer: TIMEOUT must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [OW-1:0]    asm_data_q;
  logic [RATIO-1:0] asm_keep_q;
  logic [OW-1:0]    odata_q;
  logic [RATIO-1:0] okeep_q;
  logic             olast_q;
  logic             ovalid_q;

  logic             ifire;
  logic             ofire;
  logic             iready;
  logic             last_lane;
  logic [OW-1:0]    beat_data;   // incoming beat positioned in lane cnt_q
  logic [RATIO-1:0] beat_keep;   // keep bit for lane cnt_q
  logic [OW-1:0]    word_data;   // assembly including the incoming beat
  logic [RATIO-1:0] word_keep;

  // While a word is held, a new beat may only enter when the held word
  // leaves in the same cycle, so the free slot tracks oready.
  assign iready = ovalid_q ? bus.oready : 1'b1;
  assign ifire  = bus.ivalid & iready;
  assign ofire  = ovalid_q & bus.oready;

  always_comb begin
    beat_data = {bus.idata, {(OW-IW){1'b0}}} >> (IW * cnt_q);
    beat_keep = {1'b1, {(RATIO-1){1'b0}}} >> cnt_q;
    word_data = asm_data_q | beat_data;
    word_keep = asm_keep_q | beat_keep;
    last_lane = (cnt_q == CW'(RATIO - 1));
  end

`ifdef STREAM_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q;
  logic          timeout_hit;

  // Fires on the cycle the idle count would reach TIMEOUT; a beat arriving
  // in that same cycle takes priority.
  assign timeout_hit = (state_q == ACCUM) && (cnt_q != '0) && !ifire &&
                       (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if ((state_q == ACCUM) && (cnt_q != '0) && !ifire && !timeout_hit) begin
      idle_q <= idle_q + TW'(1);
    end else begin
      idle_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      odata_q    <= '0;
      okeep_q    <= '0;
      olast_q    <= 1'b0;
      ovalid_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (ifire) begin
            if (last_lane || bus.ilast) begin
              odata_q    <= word_data;
              okeep_q    <= word_keep;
              olast_q    <= bus.ilast;
              ovalid_q   <= 1'b1;
              asm_data_q <= '0;
              asm_keep_q <= '0;
              cnt_q      <= '0;
              state_q    <= HOLD;
            end else begin
              asm_data_q <= word_data;
              asm_keep_q <= word_keep;
              cnt_q      <= cnt_q + CW'(1);
            end
          end
`ifdef STREAM_PACKER_TIMEOUT_EN
          else if (timeout_hit) begin
            odata_q    <= asm_data_q;
            okeep_q    <= asm_keep_q;
            olast_q    <= 1'b0;
            ovalid_q   <= 1'b1;
            asm_data_q <= '0;
            asm_keep_q <= '0;
            cnt_q      <= '0;
            state_q    <= HOLD;
          end
`endif
        end

        HOLD: begin
          // cnt_q is 0 here, so beat_data/beat_keep address lane 0.
          if (ofire) begin
            if (ifire) begin
              if (bus.ilast) begin
                odata_q  <= beat_data;
                okeep_q  <= beat_keep;
                olast_q  <= 1'b1;
                ovalid_q <= 1'b1;
              end else begin
                asm_data_q <= beat_data;
                asm_keep_q <= beat_keep;
                cnt_q      <= CW'(1);
                ovalid_q   <= 1'b0;
                state_q    <= ACCUM;
              end
            end else begin
              cnt_q    <= '0;
              ovalid_q <= 1'b0;
              state_q  <= ACCUM;
            end
          end
        end

        default: begin
          state_q  <= ACCUM;
          ovalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iready = iready;
  assign bus.odata  = odata_q;
  assign bus.okeep  = okeep_q;
  assign bus.olast  = olast_q;
  assign bus.ovalid = ovalid_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_stream_packer                                                  |
// | Brief  : Directed self-checking bench for stream_packer (IW=8, RATIO=4,    |
// |          TIMEOUT=16). Inputs change and outputs are sampled on the         |
// |          falling clock edge; the design acts on the rising edge.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_stream_packer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  stream_packer_if #(.IW(8), .RATIO(4)) bus ();

  stream_packer #(.IW(8), .RATIO(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one beat; returns at the falling edge after the rising edge
  // that samples it.
  task automatic beat(input logic [7:0] d, input logic l);
    bus.idata  = d;
    bus.ilast  = l;
    bus.ivalid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.ivalid = 1'b0;
    bus.ilast  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] words [0:3];
  int          nw;
  logic        ready_drop;
  int          k;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.idata  = '0;
    bus.ilast  = 1'b0;
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ovalid", {31'd0, bus.ovalid}, 32'd0);
    check("rst_odata",  bus.odata, 32'h0);
    check("rst_okeep",  {28'd0, bus.okeep}, 32'h0);
    check("rst_olast",  {31'd0, bus.olast}, 32'd0);
    check("rst_iready", {31'd0, bus.iready}, 32'd1);

    // Full word, latency of exactly one cycle after the closing beat
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    check("full_early_ovalid", {31'd0, bus.ovalid}, 32'd0);
    beat(8'h44, 1'b0);
    check("full_ovalid", {31'd0, bus.ovalid}, 32'd1);
    check("full_odata",  bus.odata, 32'h11223344);
    check("full_okeep",  {28'd0, bus.okeep}, 32'hF);
    check("full_olast",  {31'd0, bus.olast}, 32'd0);
    idle(1);
    check("full_drain", {31'd0, bus.ovalid}, 32'd0);

    // Early close by ilast
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    check("part_ovalid", {31'd0, bus.ovalid}, 32'd1);
    check("part_odata",  bus.odata, 32'hAABB0000);
    check("part_okeep",  {28'd0, bus.okeep}, 32'hC);
    check("part_olast",  {31'd0, bus.olast}, 32'd1);
    idle(1);

    // Sustained streaming: 8 beats, no stall, two words
    nw = 0;
    ready_drop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.idata  = 8'h10 + 8'(i);
      bus.ilast  = 1'b0;
      bus.ivalid = 1'b1;
      if (!bus.iready) ready_drop = 1'b1;
      @(negedge clk);
      if (bus.ovalid && nw < 4) begin
        words[nw] = bus.odata;
        nw++;
      end
    end
    idle(1);
    check("stream_no_stall", {31'd0, ready_drop}, 32'd0);
    check("stream_nwords",   nw, 32'd2);
    check("stream_word0",    words[0], 32'h10111213);
    check("stream_word1",    words[1], 32'h14151617);

    // Backpressure while a word is held
    bus.oready = 1'b0;
    beat(8'h21, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h23, 1'b0);
    beat(8'h24, 1'b0);
    bus.idata  = 8'h31;
    bus.ilast  = 1'b0;
    bus.ivalid = 1'b1;
    check("bp_iready", {31'd0, bus.iready}, 32'd0);
    repeat (2) @(negedge clk);
    check("bp_ovalid", {31'd0, bus.ovalid}, 32'd1);
    check("bp_odata",  bus.odata, 32'h21222324);
    check("bp_iready2", {31'd0, bus.iready}, 32'd0);
    bus.oready = 1'b1;
    beat(8'h31, 1'b0);
    check("bp_drained", {31'd0, bus.ovalid}, 32'd0);
    beat(8'h32, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h34, 1'b0);
    check("bp_next_odata", bus.odata, 32'h31323334);
    check("bp_next_okeep", {28'd0, bus.okeep}, 32'hF);
    idle(1);

    // ilast on the last lane gives a single full word
    beat(8'h51, 1'b0);
    beat(8'h52, 1'b0);
    beat(8'h53, 1'b0);
    beat(8'h54, 1'b1);
    check("lastlane_odata", bus.odata, 32'h51525354);
    check("lastlane_okeep", {28'd0, bus.okeep}, 32'hF);
    check("lastlane_olast", {31'd0, bus.olast}, 32'd1);
    idle(1);
    check("lastlane_noempty", {31'd0, bus.ovalid}, 32'd0);

    // Consecutive ilast beats, each a one-lane word, back to back
    beat(8'h41, 1'b1);
    check("one_a_odata", bus.odata, 32'h41000000);
    check("one_a_okeep", {28'd0, bus.okeep}, 32'h8);
    beat(8'h42, 1'b1);
    check("one_b_ovalid", {31'd0, bus.ovalid}, 32'd1);
    check("one_b_odata",  bus.odata, 32'h42000000);
    beat(8'h43, 1'b1);
    check("one_c_odata", bus.odata, 32'h43000000);
    check("one_c_olast", {31'd0, bus.olast}, 32'd1);
    idle(1);
    check("one_drain", {31'd0, bus.ovalid}, 32'd0);

    // Reset mid-word
    beat(8'h61, 1'b0);
    beat(8'h62, 1'b0);
    bus.ivalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ovalid", {31'd0, bus.ovalid}, 32'd0);
    check("midrst_okeep",  {28'd0, bus.okeep}, 32'h0);
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    check("midrst_odata", bus.odata, 32'h01020304);
    idle(1);

    // Reset while a word is held
    bus.oready = 1'b0;
    beat(8'h71, 1'b0);
    beat(8'h72, 1'b0);
    beat(8'h73, 1'b0);
    beat(8'h74, 1'b0);
    bus.ivalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("holdrst_ovalid", {31'd0, bus.ovalid}, 32'd0);
    check("holdrst_odata",  bus.odata, 32'h0);
    bus.oready = 1'b1;

    // Lone beat followed by silence
    beat(8'h5A, 1'b0);
    bus.ivalid = 1'b0;
`ifdef STREAM_PACKER_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ovalid) begin
        k = i;
        break;
      end
    end
    check("tmo_delay", k, 32'd16);
    check("tmo_odata", bus.odata, 32'h5A000000);
    check("tmo_okeep", {28'd0, bus.okeep}, 32'h8);
    check("tmo_olast", {31'd0, bus.olast}, 32'd0);
    idle(2);
`else
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.ovalid) k++;
    end
    check("notmo_silent", k, 32'd0);
    beat(8'h5B, 1'b1);
    check("notmo_odata", bus.odata, 32'h5A5B0000);
    check("notmo_okeep", {28'd0, bus.okeep}, 32'hC);
    idle(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
